// File: rtl/clock_pkg.sv
// Shared types and helpers for the wall-clock time-set front end.
// Mode encoding, BCD digit type, field limits and cycle-count helpers.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN    = 2'b00,
    MODE_SET_HH = 2'b01,
    MODE_SET_MM = 2'b10
  } mode_e;

  typedef logic [3:0] bcd_t;

  localparam int unsigned HOUR_MAX = 32'd23;
  localparam int unsigned MIN_MAX  = 32'd59;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz, input int unsigned ms);
    return (clk_hz / 32'd1000) * ms;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

  function automatic int unsigned bcd_value(input bcd_t t, input bcd_t u);
    return ({28'd0, t} * 32'd10) + {28'd0, u};
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Raw active-low push-button to single-cycle press events: 2-FF sync,
// counted debounce, rising-edge detect and optional hold-to-repeat.
module btn_conditioner
  import clock_pkg::*;
#(
  parameter int unsigned DB_CYC    = 32'd1000000,
  parameter int unsigned RP_CYC    = 32'd12500000,
  parameter bit          REPEAT_EN = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic event_o
);

  localparam int unsigned DB_W = cnt_width(DB_CYC);
  localparam int unsigned RP_W = cnt_width(RP_CYC);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [RP_W-1:0] rp_cnt_q, rp_cnt_d;
  logic            event_q, event_d;
  logic            flip_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      level_q  <= 1'b0;
      db_cnt_q <= {DB_W{1'b0}};
      rp_cnt_q <= {RP_W{1'b0}};
      event_q  <= 1'b0;
    end else begin
      sync1_q  <= ~btn_n_i;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
      rp_cnt_q <= rp_cnt_d;
      event_q  <= event_d;
    end
  end

  // A repeat is suppressed in the cycle the level releases so a release never adds a step.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = {DB_W{1'b0}};
    rp_cnt_d = {RP_W{1'b0}};
    event_d  = 1'b0;
    flip_s   = 1'b0;
    if (sync2_q != level_q) begin
      if (db_cnt_q == DB_W'(DB_CYC - 32'd1)) begin
        flip_s  = 1'b1;
        level_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(32'd1);
      end
    end else begin
      db_cnt_d = {DB_W{1'b0}};
    end
    if (flip_s) begin
      event_d = sync2_q;
    end else if (REPEAT_EN && level_q) begin
      if (rp_cnt_q == RP_W'(RP_CYC - 32'd1)) begin
        event_d  = 1'b1;
        rp_cnt_d = {RP_W{1'b0}};
      end else begin
        rp_cnt_d = rp_cnt_q + RP_W'(32'd1);
      end
    end else begin
      rp_cnt_d = {RP_W{1'b0}};
    end
  end

  assign event_o = event_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set front end: MODE/INC conditioning, RUN/SET_HH/SET_MM FSM, BCD edit
// registers, load/hold handshake to the counter chain and digit blink mask.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 32'd50000000,
  parameter int unsigned DEBOUNCE_MS = 32'd20,
  parameter int unsigned REPEAT_MS   = 32'd250,
  parameter int unsigned BLINK_HZ    = 32'd2,
  parameter int unsigned TIMEOUT_S   = 32'd10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode_n,
  input  logic       btn_inc_n,
  input  logic [3:0] cur_hh_t,
  input  logic [3:0] cur_hh_u,
  input  logic [3:0] cur_mm_t,
  input  logic [3:0] cur_mm_u,
  output logic [3:0] set_hh_t,
  output logic [3:0] set_hh_u,
  output logic [3:0] set_mm_t,
  output logic [3:0] set_mm_u,
  output logic       load,
  output logic       hold_run,
  output logic [3:0] blink_mask,
  output logic [1:0] mode
);

  localparam int unsigned DB_CYC = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int unsigned RP_CYC = ms_to_cycles(CLK_HZ, REPEAT_MS);
  localparam int unsigned BL_CYC = CLK_HZ / (32'd2 * BLINK_HZ);
  localparam int unsigned TO_CYC = CLK_HZ * TIMEOUT_S;
  localparam int unsigned BL_W   = cnt_width(BL_CYC);
  localparam int unsigned TO_W   = cnt_width(TO_CYC);

  // Out-of-range captured fields are replaced by 00 rather than clamped.
  function automatic logic [7:0] sanitize(input bcd_t t, input bcd_t u, input int unsigned max);
    if ((t > 4'd9) || (u > 4'd9) || (bcd_value(t, u) > max)) begin
      return 8'h00;
    end else begin
      return {t, u};
    end
  endfunction

  function automatic logic [7:0] bcd_inc(input bcd_t t, input bcd_t u, input int unsigned max);
    if (bcd_value(t, u) >= max) begin
      return 8'h00;
    end else if (u == 4'd9) begin
      return {t + 4'd1, 4'd0};
    end else begin
      return {t, u + 4'd1};
    end
  endfunction

  logic            mode_ev_s, inc_ev_s, inc_only_s, timeout_s, restart_s;
  mode_e           mode_q, mode_d;
  logic [7:0]      hh_q, hh_d, mm_q, mm_d;
  logic            load_q, load_d, hold_q, hold_d, phase_q, phase_d;
  logic [3:0]      blink_q, blink_d;
  logic [BL_W-1:0] bl_cnt_q, bl_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  btn_conditioner #(.DB_CYC(DB_CYC), .RP_CYC(RP_CYC), .REPEAT_EN(1'b0)) u_mode_btn (
    .clk(clk), .rst(rst), .btn_n_i(btn_mode_n), .event_o(mode_ev_s)
  );

  btn_conditioner #(.DB_CYC(DB_CYC), .RP_CYC(RP_CYC), .REPEAT_EN(1'b1)) u_inc_btn (
    .clk(clk), .rst(rst), .btn_n_i(btn_inc_n), .event_o(inc_ev_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= MODE_RUN;
      hh_q     <= 8'h00;
      mm_q     <= 8'h00;
      load_q   <= 1'b0;
      hold_q   <= 1'b0;
      phase_q  <= 1'b0;
      blink_q  <= 4'b0000;
      bl_cnt_q <= {BL_W{1'b0}};
      to_cnt_q <= {TO_W{1'b0}};
    end else begin
      mode_q   <= mode_d;
      hh_q     <= hh_d;
      mm_q     <= mm_d;
      load_q   <= load_d;
      hold_q   <= hold_d;
      phase_q  <= phase_d;
      blink_q  <= blink_d;
      bl_cnt_q <= bl_cnt_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // MODE outranks INC when both events land in the same cycle.
  always_comb begin
    mode_d     = mode_q;
    hh_d       = hh_q;
    mm_d       = mm_q;
    load_d     = 1'b0;
    hold_d     = hold_q;
    restart_s  = 1'b0;
    inc_only_s = inc_ev_s & ~mode_ev_s;
    timeout_s  = (to_cnt_q == TO_W'(TO_CYC - 32'd1));
    case (mode_q)
      MODE_RUN: begin
        if (mode_ev_s) begin
          mode_d    = MODE_SET_HH;
          hh_d      = sanitize(cur_hh_t, cur_hh_u, HOUR_MAX);
          mm_d      = sanitize(cur_mm_t, cur_mm_u, MIN_MAX);
          hold_d    = 1'b1;
          restart_s = 1'b1;
        end else begin
          hold_d = 1'b0;
        end
      end
      MODE_SET_HH: begin
        if (mode_ev_s) begin
          mode_d    = MODE_SET_MM;
          restart_s = 1'b1;
        end else if (inc_only_s) begin
          hh_d      = bcd_inc(hh_q[7:4], hh_q[3:0], HOUR_MAX);
          restart_s = 1'b1;
        end else if (timeout_s) begin
          mode_d    = MODE_RUN;
          hold_d    = 1'b0;
          restart_s = 1'b1;
        end else begin
          hold_d = 1'b1;
        end
      end
      MODE_SET_MM: begin
        if (mode_ev_s) begin
          mode_d    = MODE_RUN;
          load_d    = 1'b1;
          hold_d    = 1'b0;
          restart_s = 1'b1;
        end else if (inc_only_s) begin
          mm_d      = bcd_inc(mm_q[7:4], mm_q[3:0], MIN_MAX);
          restart_s = 1'b1;
        end else if (timeout_s) begin
          mode_d    = MODE_RUN;
          hold_d    = 1'b0;
          restart_s = 1'b1;
        end else begin
          hold_d = 1'b1;
        end
      end
      default: begin
        mode_d    = MODE_RUN;
        hold_d    = 1'b0;
        restart_s = 1'b1;
      end
    endcase
  end

  // Blink phase restarts at 0 so a freshly changed digit is visible at once.
  always_comb begin
    to_cnt_d = to_cnt_q + TO_W'(32'd1);
    bl_cnt_d = bl_cnt_q + BL_W'(32'd1);
    phase_d  = phase_q;
    blink_d  = 4'b0000;
    if ((mode_d == MODE_RUN) || mode_ev_s || inc_ev_s) begin
      to_cnt_d = {TO_W{1'b0}};
    end else begin
      to_cnt_d = to_cnt_q + TO_W'(32'd1);
    end
    if (restart_s) begin
      bl_cnt_d = {BL_W{1'b0}};
      phase_d  = 1'b0;
    end else if (bl_cnt_q == BL_W'(BL_CYC - 32'd1)) begin
      bl_cnt_d = {BL_W{1'b0}};
      phase_d  = ~phase_q;
    end else begin
      bl_cnt_d = bl_cnt_q + BL_W'(32'd1);
    end
    case (mode_d)
      MODE_SET_HH: blink_d = {phase_d, phase_d, 2'b00};
      MODE_SET_MM: blink_d = {2'b00, phase_d, phase_d};
      default:     blink_d = 4'b0000;
    endcase
  end

  assign set_hh_t   = hh_q[7:4];
  assign set_hh_u   = hh_q[3:0];
  assign set_mm_t   = mm_q[7:4];
  assign set_mm_u   = mm_q[3:0];
  assign load       = load_q;
  assign hold_run   = hold_q;
  assign blink_mask = blink_q;
  assign mode       = mode_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl at reduced clock rate: every expected
// output change is queued when a press is driven and popped when it appears.
module tb_clock_set_ctrl;

  typedef logic [19:0] snap_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode_n = 1'b1;
  logic       btn_inc_n = 1'b1;
  logic [3:0] cur_hh_t = 4'd0, cur_hh_u = 4'd0, cur_mm_t = 4'd0, cur_mm_u = 4'd0;
  logic [3:0] set_hh_t, set_hh_u, set_mm_t, set_mm_u, blink_mask;
  logic       load, hold_run;
  logic [1:0] mode;

  int    total = 0;
  int    bad = 0;
  int    load_cnt = 0;
  bit    mon_en = 1'b0;
  snap_t exp_q[$];
  snap_t prev_s;
  int    m_mode = 0, m_hh = 0, m_mm = 0;

  always #5 clk = ~clk;

  clock_set_ctrl #(
    .CLK_HZ(32'd1000), .DEBOUNCE_MS(32'd5), .REPEAT_MS(32'd20),
    .BLINK_HZ(32'd50), .TIMEOUT_S(32'd1)
  ) dut (
    .clk(clk), .rst(rst), .btn_mode_n(btn_mode_n), .btn_inc_n(btn_inc_n),
    .cur_hh_t(cur_hh_t), .cur_hh_u(cur_hh_u), .cur_mm_t(cur_mm_t), .cur_mm_u(cur_mm_u),
    .set_hh_t(set_hh_t), .set_hh_u(set_hh_u), .set_mm_t(set_mm_t), .set_mm_u(set_mm_u),
    .load(load), .hold_run(hold_run), .blink_mask(blink_mask), .mode(mode)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic snap_t dut_snap();
    return {mode, load, hold_run, set_hh_t, set_hh_u, set_mm_t, set_mm_u};
  endfunction

  function automatic snap_t model_snap(input int md, input bit ld, input bit hd);
    return {2'(md), ld, hd, 4'(m_hh / 10), 4'(m_hh % 10), 4'(m_mm / 10), 4'(m_mm % 10)};
  endfunction

  // Any change of mode/load/hold/set must match the next queued expectation.
  always @(negedge clk) begin
    snap_t s;
    s = dut_snap();
    if (load) load_cnt++;
    if (mon_en && (s != prev_s)) begin
      if (exp_q.size() == 0) check("sb_nochange", 32'(s), 32'(prev_s));
      else check("sb", 32'(s), 32'(exp_q.pop_front()));
      prev_s = s;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_mode();
    int h, m;
    case (m_mode)
      0: begin
        h = int'(cur_hh_t) * 10 + int'(cur_hh_u);
        m = int'(cur_mm_t) * 10 + int'(cur_mm_u);
        m_hh = (cur_hh_t > 4'd9 || cur_hh_u > 4'd9 || h > 23) ? 0 : h;
        m_mm = (cur_mm_t > 4'd9 || cur_mm_u > 4'd9 || m > 59) ? 0 : m;
        m_mode = 1;
        exp_q.push_back(model_snap(1, 1'b0, 1'b1));
      end
      1: begin
        m_mode = 2;
        exp_q.push_back(model_snap(2, 1'b0, 1'b1));
      end
      default: begin
        m_mode = 0;
        exp_q.push_back(model_snap(0, 1'b1, 1'b0));
        exp_q.push_back(model_snap(0, 1'b0, 1'b0));
      end
    endcase
  endtask

  task automatic model_inc();
    if (m_mode == 1) begin
      m_hh = (m_hh + 1) % 24;
      exp_q.push_back(model_snap(1, 1'b0, 1'b1));
    end else if (m_mode == 2) begin
      m_mm = (m_mm + 1) % 60;
      exp_q.push_back(model_snap(2, 1'b0, 1'b1));
    end
  endtask

  task automatic press(input bit mb, input bit ib);
    if (mb) btn_mode_n = 1'b0;
    if (ib) btn_inc_n = 1'b0;
    tick(8);
    btn_mode_n = 1'b1;
    btn_inc_n = 1'b1;
    tick(10);
  endtask

  task automatic do_mode();
    model_mode();
    press(1'b1, 1'b0);
  endtask

  task automatic do_inc(input int n);
    for (int i = 0; i < n; i++) begin
      model_inc();
      press(1'b0, 1'b1);
    end
  endtask

  task automatic set_cur(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    cur_hh_t = a; cur_hh_u = b; cur_mm_t = c; cur_mm_u = d;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick(1);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lc;
    set_cur(4'd2, 4'd3, 4'd4, 4'd5);
    tick(3);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_load_hold", 32'({load, hold_run}), 32'd0);
    check("rst_blink", 32'(blink_mask), 32'd0);
    check("rst_set", 32'({set_hh_t, set_hh_u, set_mm_t, set_mm_u}), 32'd0);
    rst = 1'b0;
    tick(2);
    prev_s = dut_snap();
    mon_en = 1'b1;

    // Bounce: low 3, high 2, low 10 -> one MODE event 7 cycles after stable low.
    model_mode();
    btn_mode_n = 1'b0; tick(3);
    btn_mode_n = 1'b1; tick(2);
    btn_mode_n = 1'b0; tick(7);
    check("bounce_early", 32'(mode), 32'd0);
    tick(1);
    check("bounce_mode", 32'(mode), 32'd1);
    check("bounce_hold", 32'(hold_run), 32'd1);
    tick(2);
    btn_mode_n = 1'b1; tick(10);
    wait_drain("bounce_drain", 20);

    // 23:45 -> 09:59 and load.
    do_inc(10);
    do_mode();
    do_inc(14);
    do_mode();
    wait_drain("set0959_drain", 20);
    check("set0959_val", 32'({set_hh_t, set_hh_u, set_mm_t, set_mm_u}), 32'h0959);
    press(1'b0, 1'b1);
    check("run_inc_ignored", 32'({mode, set_hh_t, set_hh_u}), 32'h009);

    // Capture sanitise: hours 24 and minutes 0B both become 00.
    set_cur(4'd2, 4'd4, 4'd0, 4'd11);
    do_mode();
    check("sanitize_val", 32'({set_hh_t, set_hh_u, set_mm_t, set_mm_u}), 32'h0000);
    do_mode();
    do_mode();
    wait_drain("sanitize_drain", 20);

    // Wraps: 23 -> 00 hours, 59 -> 00 minutes with hours untouched.
    set_cur(4'd2, 4'd3, 4'd5, 4'd9);
    do_mode();
    do_inc(1);
    do_mode();
    do_inc(1);
    wait_drain("wrap_drain", 20);
    check("wrap_val", 32'({set_hh_t, set_hh_u, set_mm_t, set_mm_u}), 32'h0000);

    // Hold INC 100 cycles in SET_MM from 00: first event plus 4 repeats.
    for (int i = 0; i < 5; i++) model_inc();
    btn_inc_n = 1'b0;
    tick(8);
    check("rep_first", 32'(set_mm_u), 32'd1);
    tick(19);
    check("rep_gap", 32'(set_mm_u), 32'd1);
    check("blink_mm_on", 32'(blink_mask), 32'b0011);
    tick(1);
    check("rep_second", 32'(set_mm_u), 32'd2);
    check("blink_inc_restart", 32'(blink_mask), 32'b0000);
    tick(72);
    btn_inc_n = 1'b1;
    tick(12);
    wait_drain("rep_drain", 20);
    check("rep_val", 32'({set_mm_t, set_mm_u}), 32'h05);
    do_mode();
    wait_drain("rep_load_drain", 20);

    // Timeout: idle in SET_HH returns to RUN after 1000 cycles without load.
    set_cur(4'd1, 4'd2, 4'd3, 4'd4);
    model_mode();
    lc = load_cnt;
    btn_mode_n = 1'b0;
    tick(8);
    check("to_enter", 32'(mode), 32'd1);
    btn_mode_n = 1'b1;
    tick(9);
    check("blink_hh_off", 32'(blink_mask), 32'b0000);
    tick(1);
    check("blink_hh_on", 32'(blink_mask), 32'b1100);
    m_mode = 0;
    exp_q.push_back(model_snap(0, 1'b0, 1'b0));
    tick(989);
    check("to_early", 32'(mode), 32'd1);
    tick(1);
    check("to_mode", 32'(mode), 32'd0);
    check("to_hold", 32'(hold_run), 32'd0);
    check("to_blink", 32'(blink_mask), 32'd0);
    check("to_noload", 32'(load_cnt), 32'(lc));
    wait_drain("to_drain", 5);

    // Simultaneous MODE+INC in SET_HH at 07: MODE wins; then reset mid-SET_MM.
    set_cur(4'd0, 4'd7, 4'd3, 4'd0);
    do_mode();
    model_mode();
    press(1'b1, 1'b1);
    wait_drain("simul_drain", 20);
    check("simul_state", 32'({mode, set_hh_t, set_hh_u}), 32'h207);
    lc = load_cnt;
    m_mode = 0; m_hh = 0; m_mm = 0;
    exp_q.push_back(model_snap(0, 1'b0, 1'b0));
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_mode", 32'(mode), 32'd0);
    check("rst_mid_outs", 32'({load, hold_run, blink_mask}), 32'd0);
    check("rst_mid_set", 32'({set_hh_t, set_hh_u, set_mm_t, set_mm_u}), 32'd0);
    tick(3);
    rst = 1'b0;
    tick(5);
    check("rst_mid_noload", 32'(load_cnt), 32'(lc));

    wait_drain("final_drain", 20);
    check("load_total", 32'(load_cnt), 32'd3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
